// File: rtl/inv_factorial.sv
// -----------------------------------------------------------------------------
// inv_factorial
//
// Inverse factorial decoder. For an input value V it returns the largest n
// (1 <= n <= NMAX, NMAX = 2**N_size-1) such that n! <= V. It also flags an
// exact hit (n! == V) and saturation ((NMAX+1)! <= V). V == 0 decodes to n = 0.
//
// The search multiplies a running product by (k+1) once per clock. It stops
// at the first k whose successor factorial would exceed V, or when k reaches
// NMAX. A start/done handshake frames each request. Latency from the
// accepting edge to done is max(n_out,1) edges. Back-to-back requests are
// accepted every R+2 cycles.
//
// Optional feature: define INV_FACT_REM_EN to add the rem_out_o port, which
// carries V - n_out!. It is 0 when V == 0. Without the macro the port and its
// subtractor are absent.
//
// Ports
//   clk_i       in   1        rising-edge clock
//   reset_i     in   1        asynchronous, active-high reset
//   start_i     in   1        request, sampled only while ready_o = 1
//   value_i     in   V_W      value V, captured on an accepted start
//   ready_o     out  1        high in IDLE only
//   done_o      out  1        one-cycle pulse; results valid from this cycle
//   n_out_o     out  N_size   decoded n
//   exact_o     out  1        n_out! == V
//   overflow_o  out  1        NMAX reached and (NMAX+1)! <= V
//   rem_out_o   out  V_W      V - n_out! (INV_FACT_REM_EN only)
//
// States
//   IDLE | waiting for start, ready_o = 1
//   CALC | one multiply-and-compare step per clock
//   DONE | done_o high for this single cycle, then back to IDLE
// -----------------------------------------------------------------------------
module inv_factorial #(
  parameter int N_size = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [2**(2+N_size):0]   value_i,
  output logic                     ready_o,
  output logic                     done_o,
  output logic [N_size-1:0]        n_out_o,
  output logic                     exact_o,
  output logic                     overflow_o
`ifdef INV_FACT_REM_EN
  ,
  output logic [2**(2+N_size):0]   rem_out_o
`endif
);

  localparam int V_W  = 2**(2+N_size) + 1;
  localparam int P_W  = V_W + N_size;     // product width; p*(k+1) never truncates
  localparam int NMAX = 2**N_size - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [V_W-1:0]      v_q;
  logic [V_W-1:0]      p_q;      // k! for the current k
  logic [N_size-1:0]   k_q;
  logic                done_q;
  logic [N_size-1:0]   n_q;
  logic                exact_q;
  logic                overflow_q;
`ifdef INV_FACT_REM_EN
  logic [V_W-1:0]      rem_q;
`endif

  logic [N_size:0]     kp1;
  logic [P_W-1:0]      nxt;
  logic                nxt_le_v;
  logic                at_max;

  // k+1 needs one extra bit: at k = NMAX it equals 2**N_size.
  assign kp1      = (N_size+1)'(k_q) + (N_size+1)'(1);
  assign nxt      = P_W'(p_q) * P_W'(kp1);
  assign nxt_le_v = (nxt <= P_W'(v_q));
  assign at_max   = (k_q == N_size'(NMAX));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      v_q        <= '0;
      p_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      n_q        <= '0;
      exact_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef INV_FACT_REM_EN
      rem_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // Results from the previous request stay visible until finish.
          if (start_i) begin
            v_q     <= value_i;
            k_q     <= N_size'(1);
            p_q     <= V_W'(1);
            state_q <= CALC;
          end
        end

        CALC: begin
          if (v_q == '0) begin
            n_q        <= '0;
            exact_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef INV_FACT_REM_EN
            rem_q      <= '0;
`endif
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (!at_max && nxt_le_v) begin
            // nxt <= v_q, so the upper product bits are zero here.
            p_q <= nxt[V_W-1:0];
            k_q <= kp1[N_size-1:0];
          end else begin
            n_q        <= k_q;
            // On saturation p_q = NMAX! < (NMAX+1)! <= V, so exact is 0.
            exact_q    <= (p_q == v_q);
            overflow_q <= at_max && nxt_le_v;
`ifdef INV_FACT_REM_EN
            rem_q      <= v_q - p_q;
`endif
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = done_q;
  assign n_out_o    = n_q;
  assign exact_o    = exact_q;
  assign overflow_o = overflow_q;
`ifdef INV_FACT_REM_EN
  assign rem_out_o  = rem_q;
`endif

endmodule

// File: tb/tb_inv_factorial.sv
module tb_inv_factorial;

  localparam int N_size = 3;
  localparam int V_W    = 2**(2+N_size) + 1;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic [V_W-1:0]   value_i = '0;
  logic             ready_o;
  logic             done_o;
  logic [N_size-1:0] n_out_o;
  logic             exact_o;
  logic             overflow_o;
`ifdef INV_FACT_REM_EN
  logic [V_W-1:0]   rem_out_o;
`endif

  inv_factorial #(.N_size(N_size)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .value_i    (value_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .n_out_o    (n_out_o),
    .exact_o    (exact_o),
    .overflow_o (overflow_o)
`ifdef INV_FACT_REM_EN
    ,
    .rem_out_o  (rem_out_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [V_W-1:0]    v;
    logic [N_size-1:0] n;
    logic              ex;
    logic              ov;
    logic [V_W-1:0]    rem;
    int                lat;
    int                acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ndone = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected results from a table of factorials: largest i with i! <= v.
  function automatic longint fact(input int i);
    longint f = 1;
    for (int j = 2; j <= i; j++) f = f * j;
    return f;
  endfunction

  function automatic exp_t model(input logic [V_W-1:0] v);
    exp_t   e;
    longint lv = longint'(v);
    int     n  = 0;
    if (lv != 0) begin
      n = 1;
      for (int i = 2; i <= 7; i++) if (fact(i) <= lv) n = i;
    end
    e.v   = v;
    e.n   = N_size'(n);
    e.ov  = (n == 7) && (fact(8) <= lv);
    e.ex  = (lv != 0) && (fact(n) == lv);
    e.rem = (lv == 0) ? '0 : V_W'(lv - fact(n));
    e.lat = (n == 0) ? 1 : n;
    e.acc = 0;
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  logic done_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!reset_i && done_o) begin
        ndone++;
        total++;
        if (done_prev) begin
          bad++;
          $display("FAIL done_width: done high two cycles running, required one-cycle pulse");
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_done: done=1 with no request outstanding, required 0");
        end else begin
          e = q.pop_front();
          total++;
          if (n_out_o !== e.n) begin
            bad++;
            $display("FAIL n_out V=%0d: got %0d, required %0d", e.v, n_out_o, e.n);
          end
          total++;
          if (exact_o !== e.ex) begin
            bad++;
            $display("FAIL exact V=%0d: got %0b, required %0b", e.v, exact_o, e.ex);
          end
          total++;
          if (overflow_o !== e.ov) begin
            bad++;
            $display("FAIL overflow V=%0d: got %0b, required %0b", e.v, overflow_o, e.ov);
          end
          total++;
          if ((cyc - e.acc) != e.lat) begin
            bad++;
            $display("FAIL latency V=%0d: got %0d, required %0d", e.v, cyc - e.acc, e.lat);
          end
`ifdef INV_FACT_REM_EN
          total++;
          if (rem_out_o !== e.rem) begin
            bad++;
            $display("FAIL rem_out V=%0d: got %0d, required %0d", e.v, rem_out_o, e.rem);
          end
`endif
        end
      end
      done_prev = done_o && !reset_i;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic submit(input exp_t e, output int acc);
    exp_t ee = e;
    int   w  = 0;
    while (!ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL ready_timeout V=%0d: ready=%0b, required 1", e.v, ready_o);
    end
    start_i = 1'b1;
    value_i = e.v;
    acc     = cyc + 1;
    ee.acc  = acc;
    q.push_back(ee);
    @(negedge clk_i);
    start_i = 1'b0;
    value_i = {$urandom_range(0, 1), $urandom};
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  function automatic exp_t mk(input logic [V_W-1:0] v, input int n, input logic ex,
                              input logic ov, input logic [V_W-1:0] rem, input int lat);
    exp_t e;
    e.v = v; e.n = N_size'(n); e.ex = ex; e.ov = ov; e.rem = rem; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%0b done=%0b, required 1 0", ready_o, done_o);
    end
    total++;
    if (n_out_o !== '0 || exact_o !== 1'b0 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_results: n=%0d exact=%0b ov=%0b, required 0 0 0",
               n_out_o, exact_o, overflow_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    int acc;
    submit(mk(33'd120,   5, 1'b1, 1'b0, 33'd0,     5), acc);
    drain();
    submit(mk(33'd121,   5, 1'b0, 1'b0, 33'd1,     5), acc);
    drain();
    submit(mk(33'd1,     1, 1'b1, 1'b0, 33'd0,     1), acc);
    drain();
    submit(mk(33'd0,     0, 1'b0, 1'b0, 33'd0,     1), acc);
    drain();
    submit(mk(33'd5040,  7, 1'b1, 1'b0, 33'd0,     7), acc);
    drain();
    submit(mk(33'd2,     2, 1'b1, 1'b0, 33'd0,     2), acc);
    drain();
    submit(mk(33'd40319, 7, 1'b0, 1'b0, 33'd35279, 7), acc);
    drain();
    submit(mk({1'b1, 32'hFFFF_FFFF}, 7, 1'b0, 1'b1, 33'h1_FFFF_EC4F, 7), acc);
    drain();
    submit(mk(33'd40320, 7, 1'b0, 1'b1, 33'd35280, 7), acc);
    drain();
    // Results are held after done.
    repeat (4) @(negedge clk_i);
    total++;
    if (n_out_o !== 3'd7 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL hold: n=%0d ov=%0b, required 7 1", n_out_o, overflow_o);
    end
  endtask

  task automatic test_reset_mid_calc();
    int acc;
    int d0;
    submit(mk(33'd5040, 7, 1'b1, 1'b0, 33'd0, 7), acc);
    // Now just after accepting edge; two more edges puts us at edge 3.
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b1 || done_o !== 1'b0 || n_out_o !== '0 ||
        exact_o !== 1'b0 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_calc: ready=%0b done=%0b n=%0d exact=%0b ov=%0b, required 1 0 0 0 0",
               ready_o, done_o, n_out_o, exact_o, overflow_o);
    end
`ifdef INV_FACT_REM_EN
    total++;
    if (rem_out_o !== '0) begin
      bad++;
      $display("FAIL reset_rem: got %0d, required 0", rem_out_o);
    end
`endif
    q.delete();
    d0 = ndone;
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (12) @(negedge clk_i);
    total++;
    if (ndone != d0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", ndone - d0);
    end
    submit(mk(33'd6, 3, 1'b1, 1'b0, 33'd0, 3), acc);
    drain();
  endtask

  task automatic test_ignore_start();
    int acc;
    int d0 = ndone;
    submit(mk(33'd720, 6, 1'b1, 1'b0, 33'd0, 6), acc);
    for (int i = 0; i < 3; i++) begin
      start_i = 1'b1;
      value_i = 33'd2;
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL ready_busy: ready=%0b, required 0", ready_o);
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    drain();
    repeat (10) @(negedge clk_i);
    total++;
    if (ndone - d0 != 1) begin
      bad++;
      $display("FAIL ignore_start: got %0d done pulses, required 1", ndone - d0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acc;
    int   prev_acc = 0;
    int   prev_lat = 0;
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       e = model(V_W'($urandom_range(0, 50000)));
        1:       e = model(V_W'(fact($urandom_range(1, 7))));
        default: e = model({$urandom_range(0, 1), $urandom});
      endcase
      submit(e, acc);
      if (i > 0) begin
        total++;
        if (acc - prev_acc != prev_lat + 2) begin
          bad++;
          $display("FAIL throughput #%0d: spacing %0d, required %0d", i, acc - prev_acc, prev_lat + 2);
        end
      end
      prev_acc = acc;
      prev_lat = e.lat;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_calc();
    test_ignore_start();
    test_back_to_back();
    repeat (5) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
